// File: rtl/gpio_serial_config_loader.sv
// gpio_serial_config_loader
//
// Snapshots the flat per-pad configuration bus on request and shifts it into
// the daisy-chained GPIO control blocks, farthest pad first and each word MSB
// first, using a divided serial clock. A parallel-load strobe then makes every
// control block commit its word at the same time.
//
// Ports:
//   clk              block clock
//   resetn           asynchronous active-low reset
//   xfer_start       single-cycle transfer request (ignored while busy)
//   cfg_data         flat configuration, chain position p at [(p+1)*CFG_BITS-1 : p*CFG_BITS]
//   busy             transfer in progress
//   done             one-cycle completion pulse
//   serial_clock     chain shift clock
//   serial_data_out  chain serial data
//   serial_load      chain parallel-load strobe
//
// State table:
//   IDLE     | waiting for xfer_start
//   SHIFT_LO | serial_clock low, current bit presented on serial_data_out
//   SHIFT_HI | serial_clock high, data held stable
//   LOAD     | serial_load asserted to commit all words
module gpio_serial_config_loader #(
    parameter int NUM_PADS = 27,
    parameter int CFG_BITS = 13,
    parameter int CLK_DIV  = 2
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         xfer_start,
    input  logic [NUM_PADS*CFG_BITS-1:0] cfg_data,
    output logic                         busy,
    output logic                         done,
    output logic                         serial_clock,
    output logic                         serial_data_out,
    output logic                         serial_load
);

    localparam int N  = NUM_PADS * CFG_BITS;
    localparam int BW = $clog2(N) + 1;
    localparam int DW = $clog2(CLK_DIV) + 1;

    localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT_LO = 2'd1,
        SHIFT_HI = 2'd2,
        LOAD     = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    shadow_q, shadow_d;
    logic [BW-1:0]   bitcnt_q, bitcnt_d;
    logic [DW-1:0]   divcnt_q, divcnt_d;

    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            sclk_q, sclk_d;
    logic            sdo_q, sdo_d;
    logic            load_q, load_d;

    logic            phase_end;
    logic [N-1:0]    shadow_sel;

    // State register and output flops: every output comes straight from a flop.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            bitcnt_q <= '0;
            divcnt_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sclk_q   <= 1'b0;
            sdo_q    <= 1'b0;
            load_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            bitcnt_q <= bitcnt_d;
            divcnt_q <= divcnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            sclk_q   <= sclk_d;
            sdo_q    <= sdo_d;
            load_q   <= load_d;
        end
    end

    assign phase_end = (divcnt_q == DIV_LAST);

    // Next-state logic; the divider counts cycles within the current phase.
    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        bitcnt_d = bitcnt_q;
        divcnt_d = divcnt_q;
        case (state_q)
            IDLE: begin
                if (xfer_start) begin
                    shadow_d = cfg_data;
                    bitcnt_d = BIT_LAST;
                    divcnt_d = '0;
                    state_d  = SHIFT_LO;
                end
            end
            SHIFT_LO: begin
                if (phase_end) begin
                    divcnt_d = '0;
                    state_d  = SHIFT_HI;
                end else begin
                    divcnt_d = divcnt_q + DW'(1);
                end
            end
            SHIFT_HI: begin
                if (phase_end) begin
                    divcnt_d = '0;
                    if (bitcnt_q == '0) begin
                        state_d = LOAD;
                    end else begin
                        bitcnt_d = bitcnt_q - BW'(1);
                        state_d  = SHIFT_LO;
                    end
                end else begin
                    divcnt_d = divcnt_q + DW'(1);
                end
            end
            LOAD: begin
                if (phase_end) begin
                    divcnt_d = '0;
                    state_d  = IDLE;
                end else begin
                    divcnt_d = divcnt_q + DW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic computed from the upcoming state so the registered outputs
    // line up with the state they describe.
    always_comb begin
        shadow_sel = shadow_d >> bitcnt_d;
        busy_d     = (state_d != IDLE);
        done_d     = (state_q == LOAD) && (state_d == IDLE);
        sclk_d     = (state_d == SHIFT_HI);
        load_d     = (state_d == LOAD);
        case (state_d)
            SHIFT_LO: sdo_d = shadow_sel[0];
            SHIFT_HI: sdo_d = sdo_q;   // hold data across the high phase
            default:  sdo_d = 1'b0;
        endcase
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign serial_clock    = sclk_q;
    assign serial_data_out = sdo_q;
    assign serial_load     = load_q;

endmodule

// File: tb/tb_gpio_serial_config_loader.sv
// Testbench for gpio_serial_config_loader: three instances with different
// parameter sets, a timeline model of the expected output waveform, and
// directed scenarios with hand-computed stream/latency values.
module tb_gpio_serial_config_loader;

    localparam int NA = 26,  DA = 2, TA = (2 * NA + 1) * DA + 1;
    localparam int NB = 13,  DB = 1, TB = (2 * NB + 1) * DB + 1;
    localparam int NC = 351, DC = 2, TC = (2 * NC + 1) * DC + 1;

    logic clk = 1'b0;
    int   cyc = 0;
    int   nerr = 0;
    int   nchk = 0;

    logic          rstn_a = 1'b0, xs_a = 1'b0;
    logic [25:0]   cfg_a = '0;
    logic          busy_a, done_a, sclk_a, sod_a, load_a;
    logic          rstn_b = 1'b0, xs_b = 1'b0;
    logic [12:0]   cfg_b = '0;
    logic          busy_b, done_b, sclk_b, sod_b, load_b;
    logic          rstn_c = 1'b0, xs_c = 1'b0;
    logic [350:0]  cfg_c = '0;
    logic          busy_c, done_c, sclk_c, sod_c, load_c;

    gpio_serial_config_loader #(.NUM_PADS(2), .CFG_BITS(13), .CLK_DIV(2)) dut_a (
        .clk(clk), .resetn(rstn_a), .xfer_start(xs_a), .cfg_data(cfg_a),
        .busy(busy_a), .done(done_a), .serial_clock(sclk_a),
        .serial_data_out(sod_a), .serial_load(load_a));
    gpio_serial_config_loader #(.NUM_PADS(1), .CFG_BITS(13), .CLK_DIV(1)) dut_b (
        .clk(clk), .resetn(rstn_b), .xfer_start(xs_b), .cfg_data(cfg_b),
        .busy(busy_b), .done(done_b), .serial_clock(sclk_b),
        .serial_data_out(sod_b), .serial_load(load_b));
    gpio_serial_config_loader #(.NUM_PADS(27), .CFG_BITS(13), .CLK_DIV(2)) dut_c (
        .clk(clk), .resetn(rstn_c), .xfer_start(xs_c), .cfg_data(cfg_c),
        .busy(busy_c), .done(done_c), .serial_clock(sclk_c),
        .serial_data_out(sod_c), .serial_load(load_c));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // Expected {busy, done, serial_clock, serial_data_out, serial_load} for the
    // t-th cycle after the accepting edge (t=1 is the first cycle after it).
    function automatic logic [4:0] exp_out(input logic a, input int t, input int n,
                                           input int d, input logic [350:0] snap);
        int ph;
        exp_out = '0;
        if (!a) return exp_out;
        if (t >= 1 && t <= 2 * n * d) begin
            ph = (t - 1) / d;
            exp_out[4] = 1'b1;
            exp_out[2] = (ph % 2) == 1;
            exp_out[1] = snap[n - 1 - ph / 2];
        end else if (t <= (2 * n + 1) * d) begin
            exp_out[4] = 1'b1;
            exp_out[0] = 1'b1;
        end else if (t == (2 * n + 1) * d + 1) begin
            exp_out[3] = 1'b1;
        end
    endfunction

    // Model timelines: a start is taken when idle or in the done cycle.
    logic act_a = 1'b0, act_b = 1'b0, act_c = 1'b0;
    int   t_a = 0, t_b = 0, t_c = 0;
    logic [350:0] snap_a = '0, snap_b = '0, snap_c = '0;

    always @(posedge clk or negedge rstn_a)
        if (!rstn_a) begin act_a <= 1'b0; t_a <= 0; end
        else if ((!act_a || t_a == TA) && xs_a) begin act_a <= 1'b1; t_a <= 1; snap_a <= 351'(cfg_a); end
        else if (act_a) begin if (t_a == TA) act_a <= 1'b0; else t_a <= t_a + 1; end

    always @(posedge clk or negedge rstn_b)
        if (!rstn_b) begin act_b <= 1'b0; t_b <= 0; end
        else if ((!act_b || t_b == TB) && xs_b) begin act_b <= 1'b1; t_b <= 1; snap_b <= 351'(cfg_b); end
        else if (act_b) begin if (t_b == TB) act_b <= 1'b0; else t_b <= t_b + 1; end

    always @(posedge clk or negedge rstn_c)
        if (!rstn_c) begin act_c <= 1'b0; t_c <= 0; end
        else if ((!act_c || t_c == TC) && xs_c) begin act_c <= 1'b1; t_c <= 1; snap_c <= cfg_c; end
        else if (act_c) begin if (t_c == TC) act_c <= 1'b0; else t_c <= t_c + 1; end

    // Observation: per-cycle compare, captured streams and event counters.
    logic [399:0] str_a = '0, str_b = '0, str_c = '0;
    logic psclk_a = 1'b0, psclk_b = 1'b0, psclk_c = 1'b0, psod_c = 1'b0;
    int edges_a = 0, edges_b = 0, edges_c = 0;
    int dones_a = 0, loads_a = 0;

    always @(negedge clk) begin
        chk("a_outputs", 32'({busy_a, done_a, sclk_a, sod_a, load_a}), 32'(exp_out(act_a, t_a, NA, DA, snap_a)));
        chk("b_outputs", 32'({busy_b, done_b, sclk_b, sod_b, load_b}), 32'(exp_out(act_b, t_b, NB, DB, snap_b)));
        chk("c_outputs", 32'({busy_c, done_c, sclk_c, sod_c, load_c}), 32'(exp_out(act_c, t_c, NC, DC, snap_c)));
        if (busy_c && sclk_c) chk("c_sod_hold", 32'(sod_c), 32'(psod_c));
        if (sclk_a && !psclk_a) begin str_a = {str_a[398:0], sod_a}; edges_a++; end
        if (sclk_b && !psclk_b) begin str_b = {str_b[398:0], sod_b}; edges_b++; end
        if (sclk_c && !psclk_c) begin str_c = {str_c[398:0], sod_c}; edges_c++; end
        if (done_a) dones_a++;
        if (load_a) loads_a++;
        psclk_a = sclk_a; psclk_b = sclk_b; psclk_c = sclk_c; psod_c = sod_c;
    end

    task automatic set_xs(input int w, input logic v);
        case (w)
            0: xs_a = v;
            1: xs_b = v;
            default: xs_c = v;
        endcase
    endtask

    task automatic pulse_start(input int w, output int k);
        @(negedge clk);
        set_xs(w, 1'b1);
        @(posedge clk);
        #1 k = cyc;
        @(negedge clk);
        set_xs(w, 1'b0);
    endtask

    // Returns the done-cycle edge index, or -1 after the budget runs out.
    task automatic wait_done(input int w, input int budget, output int dcyc);
        dcyc = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if ((w == 0 && done_a) || (w == 1 && done_b) || (w == 2 && done_c)) begin
                dcyc = cyc;
                return;
            end
        end
        chk("done_timeout", 32'd1, 32'd0);
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    initial begin
        int k, d, e0, l0, n0;
        logic [351:0] rnd;

        repeat (3) @(negedge clk);
        chk("a_reset_outs", 32'({busy_a, done_a, sclk_a, sod_a, load_a}), 32'd0);
        chk("b_reset_outs", 32'({busy_b, done_b, sclk_b, sod_b, load_b}), 32'd0);
        chk("c_reset_outs", 32'({busy_c, done_c, sclk_c, sod_c, load_c}), 32'd0);
        rstn_a = 1'b1; rstn_b = 1'b1; rstn_c = 1'b1;
        repeat (2) @(negedge clk);

        // alternating pattern, latency, edge and load-cycle counts
        cfg_a = 26'h2AAAAAA;
        e0 = edges_a; l0 = loads_a;
        pulse_start(0, k);
        wait_done(0, 200, d);
        chk("a1_latency", 32'(d - k + 1), 32'd107);
        settle();
        chk("a1_stream", 32'(str_a[25:0]), 32'h2AAAAAA);
        chk("a1_edges", 32'(edges_a - e0), 32'd26);
        chk("a1_load_cycles", 32'(loads_a - l0), 32'd2);

        // cfg_data changes after the snapshot are ignored
        cfg_a = 26'h1ABCDEF;
        pulse_start(0, k);
        repeat (4) @(negedge clk);
        cfg_a = 26'h0;
        wait_done(0, 200, d);
        settle();
        chk("a2_stream", 32'(str_a[25:0]), 32'h1ABCDEF);

        // starts while busy are dropped; a start on the done cycle is taken
        cfg_a = 26'h3C0FF03;
        n0 = dones_a;
        pulse_start(0, k);
        repeat (8) @(negedge clk);
        xs_a = 1'b1; @(negedge clk); xs_a = 1'b0;
        repeat (39) @(negedge clk);
        xs_a = 1'b1; @(negedge clk); xs_a = 1'b0;
        wait_done(0, 200, d);
        chk("a3_latency", 32'(d - k + 1), 32'd107);
        cfg_a = 26'h0123456;
        xs_a = 1'b1;
        @(posedge clk);
        #1 k = cyc;
        @(negedge clk);
        xs_a = 1'b0;
        wait_done(0, 200, d);
        chk("a3_b2b_latency", 32'(d - k + 1), 32'd107);
        settle();
        chk("a3_done_count", 32'(dones_a - n0), 32'd2);
        chk("a3_b2b_stream", 32'(str_a[25:0]), 32'h0123456);

        // asynchronous reset in the middle of a high phase
        cfg_a = 26'h2AAAAAA;
        n0 = dones_a; l0 = loads_a;
        pulse_start(0, k);
        repeat (30) @(posedge clk);
        #2;
        chk("a4_pre_rst_sclk", 32'(sclk_a), 32'd1);
        rstn_a = 1'b0;
        #1;
        chk("a4_rst_outs", 32'({busy_a, sclk_a, load_a, sod_a, done_a}), 32'd0);
        repeat (3) @(negedge clk);
        rstn_a = 1'b1;
        repeat (120) @(negedge clk);
        #1;
        chk("a4_no_done", 32'(dones_a - n0), 32'd0);
        chk("a4_no_load", 32'(loads_a - l0), 32'd0);
        cfg_a = 26'h155AA33;
        pulse_start(0, k);
        wait_done(0, 200, d);
        chk("a4_after_latency", 32'(d - k + 1), 32'd107);
        settle();
        chk("a4_after_stream", 32'(str_a[25:0]), 32'h155AA33);

        // undivided clock, single pad
        cfg_b = 13'h1001;
        e0 = edges_b;
        pulse_start(1, k);
        wait_done(1, 60, d);
        chk("b_latency", 32'(d - k + 1), 32'd28);
        settle();
        chk("b_stream", 32'(str_b[12:0]), 32'h1001);
        chk("b_edges", 32'(edges_b - e0), 32'd13);

        // full 27-pad chain with random data
        for (int i = 0; i < 11; i++) rnd[i * 32 +: 32] = $urandom;
        cfg_c = rnd[350:0];
        e0 = edges_c;
        pulse_start(2, k);
        wait_done(2, 1600, d);
        chk("c_latency", 32'(d - k + 1), 32'd1407);
        settle();
        chk("c_stream", 32'(str_c[350:0] === cfg_c), 32'd1);
        chk("c_edges", 32'(edges_c - e0), 32'd351);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
